int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller sitting directly upstream of the monocycle control unit.
- Collects up to four external request lines (one per I/O port), latches edges as pending, masks and prioritises them.
- Drives the single-cycle `s_interrup` pulse that makes the control unit push the PC, and supplies the ISR address to the PC mux.
- Holds off further interrupts until the control unit signals `finInterrup` on return-from-interrupt.

Parameters:
- N_IRQ, 4, number of request lines (fixed at 4 in this revision; ID width 2).
- PC_W, 10, width of the program counter / vector output.
- VEC_BASE, 10'h3C0, ISR address for line 0.
- VEC_STRIDE, 16, address distance between consecutive ISR entry points.
- MASK_RST, 4'b1111, reset value of the enable mask (1 = enabled).
- TMR_PERIOD, 1000, timer period in cycles (used only with INTC_TIMER_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- irq_in  in  4  external request lines, already synchronous to clk, rising-edge sensitive
- mask_we  in  1  write strobe for mask register
- mask_d  in  4  new mask value
- finInterrup  in  1  from control unit, high during the return-from-interrupt cycle
- s_interrup  out  1  to control unit, one-cycle interrupt-take pulse
- int_vector  out  PC_W  ISR address, valid while s_interrup=1 and held through service
- int_id  out  2  index of interrupt being serviced
- int_active  out  1  high from take cycle until finInterrup accepted
- pending  out  4  pending request bits, for debug/status

Behaviour:
- Reset (reset=0 at a clk edge):
  - pending=0, irq_q=0, mask=MASK_RST, state=IDLE.
  - s_interrup=0, int_active=0, int_id=0, int_vector=VEC_BASE.
  - Reset mid-service abandons the service silently.
- Edge detect:
  - irq_q <= irq_in each cycle; rise = irq_in & ~irq_q.
  - A rise sets the matching pending bit on the same edge. Level-held lines produce only one request.
- Mask:
  - On mask_we=1, mask <= mask_d at the edge.
  - Masking never clears pending; an unmasked pending bit becomes eligible the next cycle.
- Eligibility: elig = pending & mask. Priority is fixed, lowest index highest (line 0 wins).
- FSM, all outputs registered:
  - IDLE: if elig != 0, go to TAKE. On the same edge, latch int_id = highest-priority index and int_vector = VEC_BASE + int_id*VEC_STRIDE (modulo 2^PC_W), and clear that pending bit.
  - TAKE: s_interrup=1 and int_active=1 for exactly this one cycle. The control unit pushes the PC now and the PC loads int_vector. Next state is SERVICE unconditionally.
  - SERVICE: s_interrup=0, int_active=1, int_id/int_vector held. On finInterrup=1, go to IDLE and drop int_active.
- Latency:
  - Rise at edge k sets pending at k.
  - TAKE is entered at edge k+1, so s_interrup is visible in cycle k+1 → k+2.
  - Minimum 2 cycles from the request edge to the s_interrup pulse.
- No nesting: new rises during TAKE/SERVICE only set pending. They are evaluated in IDLE, the cycle after finInterrup is accepted.
- Simultaneous events:
  - A new rise on the same line being cleared in IDLE→TAKE: the set wins, so the bit stays pending.
  - mask_we in the same cycle as selection: selection uses the old mask.
- finInterrup is ignored in IDLE and TAKE.
- Multiple pending bits are serviced back-to-back in priority order, each with its own TAKE pulse.

Optional Feature:
- Macro: INTC_TIMER_EN.
- Defined:
  - Adds a free-running counter 0..TMR_PERIOD-1, reset to 0.
  - Wrap generates a one-cycle tick that is ORed into the rise term of line 3. Line 3 is then set by either irq_in[3] rising or the timer tick.
  - Counter keeps running during service; a tick while bit 3 is already pending is absorbed.
- Undefined: no counter logic; line 3 is driven only by irq_in[3].

Decomposition:
- Shared package intc_pkg:
  - State enum {IDLE, TAKE, SERVICE}.
  - IRQ_ID_W=2.
  - Default VEC_BASE/VEC_STRIDE constants.
  - Function for vector computation.
- One natural sub-module: intc_prio_enc (4-bit elig → valid + 2-bit index, lowest index wins), purely combinational.
- Timer lives inline under the macro.

Test Plan:
- Single request: reset, then irq_in[2] 0→1 at cycle 5 → pending[2]=1 at cycle 6; s_interrup=1 only in cycle 7, int_id=2, int_vector=10'h3E0; finInterrup at cycle 12 → int_active=0 at cycle 13.
- Priority: irq_in[1] and irq_in[3] rise together → line 1 taken first (vector 10'h3D0). After finInterrup, line 3 taken (10'h3F0) with a second one-cycle pulse.
- Masking: mask_d=4'b1110 written, irq_in[0] rises → no s_interrup, pending[0]=1. Write mask 4'b1111 → take occurs 1 cycle later with int_id=0.
- No nesting / level hold: irq_in[0] held high 50 cycles during service of line 2 → exactly one additional take for line 0, after finInterrup.
- Reset mid-service: reset=0 while in SERVICE with pending=4'b1000 → next cycle all outputs at reset values, pending=0, mask=4'b1111.
- INTC_TIMER_EN, TMR_PERIOD=8: no external irq → s_interrup pulses with int_id=3 every 8 cycles while finInterrup is returned within 4 cycles.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types, constants and helpers for the int_ctrl interrupt controller.
// Optional build feature: INTC_TIMER_EN adds a periodic timer request on line 3.
package intc_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    // Width of the serviced-interrupt index (four lines)
    localparam int unsigned IRQ_ID_W = 2;

    // Default vector table placement
    localparam logic [9:0]  VEC_BASE_DEF   = 10'h3C0;
    localparam int unsigned VEC_STRIDE_DEF = 16;

    // ISR entry address for a given line; the caller truncates to the PC width,
    // which gives the modulo-2^PC_W wrap of the vector table.
    function automatic logic [31:0] intc_vec_calc(
        input logic [31:0]         base,
        input logic [31:0]         stride,
        input logic [IRQ_ID_W-1:0] id
    );
        return base + (32'(id) * stride);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder for four eligible request bits; line 0 has the
// highest priority. Purely combinational.
module intc_prio_enc
    import intc_pkg::*;
(
    input  logic [3:0]          elig,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] idx
);

    // Pick the lowest-numbered eligible line
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        if (elig[0]) begin
            valid = 1'b1;
            idx   = 2'd0;
        end else if (elig[1]) begin
            valid = 1'b1;
            idx   = 2'd1;
        end else if (elig[2]) begin
            valid = 1'b1;
            idx   = 2'd2;
        end else if (elig[3]) begin
            valid = 1'b1;
            idx   = 2'd3;
        end else begin
            valid = 1'b0;
            idx   = 2'd0;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller in front of the monocycle control unit: latches rising
// edges of four request lines as pending, masks and prioritises them, issues a
// one-cycle s_interrup take pulse with the ISR vector, and blocks further takes
// until finInterrup closes the service.
// Optional build feature: INTC_TIMER_EN adds a free-running TMR_PERIOD counter
// whose wrap tick raises a request on line 3.
module int_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned       N_IRQ      = 4,
    parameter int unsigned       PC_W       = 10,
    parameter logic [PC_W-1:0]   VEC_BASE   = PC_W'(VEC_BASE_DEF),
    parameter int unsigned       VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [N_IRQ-1:0]  MASK_RST   = 4'b1111
`ifdef INTC_TIMER_EN
    ,
    parameter int unsigned       TMR_PERIOD = 1000
`endif
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IRQ-1:0]    irq_in,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_d,
    input  logic                finInterrup,
    output logic                s_interrup,
    output logic [PC_W-1:0]     int_vector,
    output logic [IRQ_ID_W-1:0] int_id,
    output logic                int_active,
    output logic [N_IRQ-1:0]    pending
);

    logic [N_IRQ-1:0]    irq_q_r;
    logic [N_IRQ-1:0]    pending_r;
    logic [N_IRQ-1:0]    mask_r;
    logic [N_IRQ-1:0]    rise_s;
    logic [N_IRQ-1:0]    elig_s;
    logic [N_IRQ-1:0]    clr_s;
    logic [N_IRQ-1:0]    pending_nxt_s;
    intc_state_e         state_r;
    intc_state_e         state_nxt_s;
    logic                take_s;
    logic                enc_valid_s;
    logic [IRQ_ID_W-1:0] enc_idx_s;
    logic [PC_W-1:0]     vec_nxt_s;
    logic                s_interrup_r;
    logic                int_active_r;
    logic [IRQ_ID_W-1:0] int_id_r;
    logic [PC_W-1:0]     int_vector_r;

`ifdef INTC_TIMER_EN
    localparam int unsigned TMR_W = (TMR_PERIOD > 1) ? $clog2(TMR_PERIOD) : 1;

    logic [TMR_W-1:0] tmr_cnt_r;
    logic             tmr_tick_s;

    // Tick on the last count of each timer period
    always_comb begin
        tmr_tick_s = (tmr_cnt_r == TMR_W'(TMR_PERIOD - 1));
    end

    // Free-running period counter; keeps counting while an ISR is in service
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr_cnt_r <= {TMR_W{1'b0}};
        end else if (tmr_tick_s) begin
            tmr_cnt_r <= {TMR_W{1'b0}};
        end else begin
            tmr_cnt_r <= tmr_cnt_r + TMR_W'(1);
        end
    end

    // Rising-edge detect; the timer tick acts as an extra rise on line 3
    always_comb begin
        rise_s            = irq_in & ~irq_q_r;
        rise_s[N_IRQ-1]   = rise_s[N_IRQ-1] | tmr_tick_s;
    end
`else
    // Rising-edge detect; a line held high produces a single request
    always_comb begin
        rise_s = irq_in & ~irq_q_r;
    end
`endif

    // Only enabled pending lines compete for service
    always_comb begin
        elig_s = pending_r & mask_r;
    end

    intc_prio_enc u_prio_enc (
        .elig  (elig_s),
        .valid (enc_valid_s),
        .idx   (enc_idx_s)
    );

    // ISR address of the line currently winning arbitration
    always_comb begin
        vec_nxt_s = PC_W'(intc_vec_calc(32'(VEC_BASE), 32'(VEC_STRIDE), enc_idx_s));
    end

    // Next-state logic: take from IDLE only, one TAKE cycle, wait for return
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (enc_valid_s) begin
                    state_nxt_s = TAKE;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TAKE: begin
                state_nxt_s = SERVICE;
            end
            SERVICE: begin
                if (finInterrup) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pending update: clear the taken line, but a same-cycle rise wins
    always_comb begin
        clr_s = {N_IRQ{1'b0}};
        if (take_s) begin
            clr_s[enc_idx_s] = 1'b1;
        end else begin
            clr_s = {N_IRQ{1'b0}};
        end
        pending_nxt_s = (pending_r & ~clr_s) | rise_s;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture, pending latch and enable mask
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q_r   <= {N_IRQ{1'b0}};
            pending_r <= {N_IRQ{1'b0}};
            mask_r    <= MASK_RST;
        end else begin
            irq_q_r   <= irq_in;
            pending_r <= pending_nxt_s;
            if (mask_we) begin
                mask_r <= mask_d;
            end
        end
    end

    // Registered control-unit outputs; id and vector held until the next take
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_interrup_r <= 1'b0;
            int_active_r <= 1'b0;
            int_id_r     <= {IRQ_ID_W{1'b0}};
            int_vector_r <= VEC_BASE;
        end else begin
            s_interrup_r <= (state_nxt_s == TAKE);
            int_active_r <= (state_nxt_s != IDLE);
            if (take_s) begin
                int_id_r     <= enc_idx_s;
                int_vector_r <= vec_nxt_s;
            end
        end
    end

    assign s_interrup = s_interrup_r;
    assign int_active = int_active_r;
    assign int_id     = int_id_r;
    assign int_vector = int_vector_r;
    assign pending    = pending_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (default build). Expected takes
// are queued when a request is driven and popped when s_interrup pulses.
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       finInterrup;
    logic       s_interrup;
    logic [9:0] int_vector;
    logic [1:0] int_id;
    logic       int_active;
    logic [3:0] pending;

    typedef struct {
        logic [1:0] id;
        logic [9:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert;
    int   n_fail;

    int_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_d      (mask_d),
        .finInterrup (finInterrup),
        .s_interrup  (s_interrup),
        .int_vector  (int_vector),
        .int_id      (int_id),
        .int_active  (int_active),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [9:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    // Wait up to budget cycles for a take pulse, score it, and confirm it is one cycle wide
    task automatic wait_take(input string tag, input int budget, output int waited);
        exp_t e;
        bit   found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            @(negedge clk);
            waited++;
            if (s_interrup === 1'b1) found = 1'b1;
        end
        check({tag, " take_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, " sb_has_entry"}, 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({tag, " int_id"}, 32'(int_id), 32'(e.id));
                check({tag, " int_vector"}, 32'(int_vector), 32'(e.vec));
                check({tag, " active_at_take"}, 32'(int_active), 32'd1);
            end
            @(negedge clk);
            check({tag, " pulse_one_cycle"}, 32'(s_interrup), 32'd0);
            check({tag, " active_in_service"}, 32'(int_active), 32'd1);
            check({tag, " id_held"}, 32'(int_id), 32'(e.id));
        end
    endtask

    // Return from interrupt after a short service
    task automatic end_service(input string tag);
        repeat (2) @(negedge clk);
        finInterrup = 1'b1;
        @(negedge clk);
        finInterrup = 1'b0;
        check({tag, " active_dropped"}, 32'(int_active), 32'd0);
    endtask

    // Count take pulses over a window of cycles
    task automatic count_takes(input int cycles, output int takes);
        takes = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (s_interrup === 1'b1) takes++;
        end
    endtask

    initial begin
        int w;
        int t;
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        irq_in      = 4'b0000;
        mask_we     = 1'b0;
        mask_d      = 4'b0000;
        finInterrup = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst s_interrup", 32'(s_interrup), 32'd0);
        check("rst int_active", 32'(int_active), 32'd0);
        check("rst int_id", 32'(int_id), 32'd0);
        check("rst int_vector", 32'(int_vector), 32'h3C0);
        check("rst pending", 32'(pending), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single request on line 2, minimum latency
        irq_in = 4'b0100;
        push_exp(2'd2, 10'h3E0);
        @(negedge clk);
        check("single pending_set", 32'(pending), 32'h4);
        check("single no_early_take", 32'(s_interrup), 32'd0);
        wait_take("single", 1, w);
        check("single pending_cleared", 32'(pending), 32'd0);
        end_service("single");
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        // finInterrup in IDLE has no effect
        finInterrup = 1'b1;
        @(negedge clk);
        finInterrup = 1'b0;
        check("idle_fin active", 32'(int_active), 32'd0);

        // Priority: lines 1 and 3 together
        irq_in = 4'b1010;
        push_exp(2'd1, 10'h3D0);
        push_exp(2'd3, 10'h3F0);
        wait_take("prio1", 3, w);
        check("prio pending_3_left", 32'(pending), 32'h8);
        end_service("prio1");
        wait_take("prio3", 3, w);
        end_service("prio3");
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        // Masking: masked line stays pending, unmask takes one cycle later
        mask_we = 1'b1;
        mask_d  = 4'b1110;
        @(negedge clk);
        mask_we = 1'b0;
        irq_in  = 4'b0001;
        count_takes(6, t);
        check("mask no_take", 32'(t), 32'd0);
        check("mask pending0", 32'(pending), 32'h1);
        mask_we = 1'b1;
        mask_d  = 4'b1111;
        push_exp(2'd0, 10'h3C0);
        wait_take("unmask", 4, w);
        mask_we = 1'b0;
        check("unmask latency", 32'(w), 32'd2);
        end_service("unmask");
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        // No nesting, level-held line 0 during service of line 2
        irq_in = 4'b0100;
        push_exp(2'd2, 10'h3E0);
        wait_take("lvl2", 3, w);
        irq_in = 4'b0101;
        count_takes(50, t);
        check("lvl no_nesting", 32'(t), 32'd0);
        check("lvl pending0", 32'(pending), 32'h1);
        push_exp(2'd0, 10'h3C0);
        end_service("lvl2");
        wait_take("lvl0", 3, w);
        end_service("lvl0");
        count_takes(10, t);
        check("lvl single_request", 32'(t), 32'd0);
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        // New rise on the line being cleared: the set wins
        mask_we = 1'b1;
        mask_d  = 4'b1101;
        @(negedge clk);
        mask_we = 1'b0;
        irq_in  = 4'b0010;
        @(negedge clk);
        irq_in  = 4'b0000;
        @(negedge clk);
        check("setwin pending1", 32'(pending), 32'h2);
        mask_we = 1'b1;
        mask_d  = 4'b1111;
        @(negedge clk);
        check("setwin old_mask_no_take", 32'(s_interrup), 32'd0);
        mask_we = 1'b0;
        irq_in  = 4'b0010;
        push_exp(2'd1, 10'h3D0);
        wait_take("setwin_a", 1, w);
        check("setwin still_pending", 32'(pending), 32'h2);
        push_exp(2'd1, 10'h3D0);
        end_service("setwin_a");
        wait_take("setwin_b", 3, w);
        end_service("setwin_b");
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset in the middle of a service with line 3 pending and mask changed
        irq_in = 4'b0100;
        push_exp(2'd2, 10'h3E0);
        wait_take("midrst", 3, w);
        irq_in  = 4'b1100;
        mask_we = 1'b1;
        mask_d  = 4'b0101;
        @(negedge clk);
        mask_we = 1'b0;
        check("midrst pending3", 32'(pending), 32'h8);
        check("midrst active", 32'(int_active), 32'd1);
        reset  = 1'b0;
        irq_in = 4'b0000;
        @(negedge clk);
        check("midrst s_interrup", 32'(s_interrup), 32'd0);
        check("midrst int_active", 32'(int_active), 32'd0);
        check("midrst int_id", 32'(int_id), 32'd0);
        check("midrst int_vector", 32'(int_vector), 32'h3C0);
        check("midrst pending", 32'(pending), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        irq_in = 4'b0010;
        push_exp(2'd1, 10'h3D0);
        wait_take("postrst_mask", 3, w);
        end_service("postrst_mask");
        irq_in = 4'b0000;
        repeat (2) @(negedge clk);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
